// File: rtl/i2c_mon_pkg.sv
// Shared types and helpers for the I2C bus monitor blocks.
package i2c_mon_pkg;

  localparam int BITS_PER_BYTE = 8;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_DATA = 3'd1,
    ST_ACK  = 3'd2,
    ST_HIT  = 3'd3,
    ST_FAIL = 3'd4
  } state_t;

  // Effective compare length: 0 means "one byte", oversize saturates at the maximum.
  function automatic int clamp_len(input int len, input int max_len);
    int eff;
    if (len == 32'sd0) begin
      eff = 32'sd1;
    end else if (len > max_len) begin
      eff = max_len;
    end else begin
      eff = len;
    end
    return eff;
  endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronises raw scl/sda into the clk domain and flags START, STOP and scl rising edges.
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic scl,
  input  logic sda,
  output logic sda_s,
  output logic start,
  output logic stop,
  output logic rise
);

  logic [SYNC_STAGES-1:0] scl_sync_r;
  logic [SYNC_STAGES-1:0] sda_sync_r;
  logic                   scl_p_r;
  logic                   sda_p_r;
  logic                   scl_s;

  // Synchroniser chains plus previous-sample flops; reset to the idle-bus level (high).
  always_ff @(posedge clk) begin
    if (reset) begin
      scl_sync_r <= {SYNC_STAGES{1'b1}};
      sda_sync_r <= {SYNC_STAGES{1'b1}};
      scl_p_r    <= 1'b1;
      sda_p_r    <= 1'b1;
    end else begin
      scl_sync_r <= {scl_sync_r[SYNC_STAGES-2:0], scl};
      sda_sync_r <= {sda_sync_r[SYNC_STAGES-2:0], sda};
      scl_p_r    <= scl_sync_r[SYNC_STAGES-1];
      sda_p_r    <= sda_sync_r[SYNC_STAGES-1];
    end
  end

  assign scl_s = scl_sync_r[SYNC_STAGES-1];
  assign sda_s = sda_sync_r[SYNC_STAGES-1];

  // START/STOP need scl high on both samples, so they can never coincide with a rise.
  assign start = scl_s & scl_p_r & sda_p_r & ~sda_s;
  assign stop  = scl_s & scl_p_r & ~sda_p_r & sda_s;
  assign rise  = scl_s & ~scl_p_r;

endmodule

// File: rtl/i2c_pattern_matcher.sv
// Passive I2C monitor: compares each frame's bytes with a masked pattern and pulses match/mismatch.
module i2c_pattern_matcher
  import i2c_mon_pkg::*;
#(
  parameter int N_BYTES     = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16,
  localparam int LW         = $clog2(N_BYTES + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   scl,
  input  logic                   sda,
  input  logic [8*N_BYTES-1:0]   pattern,
  input  logic [8*N_BYTES-1:0]   mask,
  input  logic [LW-1:0]          pattern_len,
  output logic                   match,
  output logic                   mismatch,
  output logic                   busy,
  output logic [7:0]             rx_byte,
  output logic                   rx_valid,
  output logic                   ack_bit,
  output logic [LW-1:0]          byte_cnt,
  output logic [CNT_W-1:0]       match_count,
  output logic [2:0]             state_dbg
);

  logic sda_s;
  logic start_s;
  logic stop_s;
  logic rise_s;

  i2c_bus_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .scl   (scl),
    .sda   (sda),
    .sda_s (sda_s),
    .start (start_s),
    .stop  (stop_s),
    .rise  (rise_s)
  );

  state_t               state_r,    state_n;
  logic [2:0]           bit_cnt_r,  bit_cnt_n;
  logic [7:0]           shift_r,    shift_n;
  logic [LW-1:0]        byte_cnt_r, byte_cnt_n;
  logic [LW-1:0]        len_r,      len_n;
  logic [8*N_BYTES-1:0] pat_r,      pat_n;
  logic [8*N_BYTES-1:0] mask_r,     mask_n;
  logic                 busy_r,     busy_n;
  logic [7:0]           rx_byte_r,  rx_byte_n;
  logic                 rx_valid_r, rx_valid_n;
  logic                 ack_r,      ack_n;
  logic                 match_r,    match_n;
  logic                 mismatch_r, mismatch_n;
  logic [CNT_W-1:0]     count_r,    count_n;

  logic [7:0]           pat_byte_s;
  logic [7:0]           mask_byte_s;
  logic [LW-1:0]        byte_inc_s;
  logic                 byte_bad_s;

  // Expected byte and mask for the byte currently being acknowledged.
  always_comb begin
    pat_byte_s  = 8'(pat_r  >> (int'(byte_cnt_r) * BITS_PER_BYTE));
    mask_byte_s = 8'(mask_r >> (int'(byte_cnt_r) * BITS_PER_BYTE));
    byte_bad_s  = (byte_cnt_r < len_r) && (((shift_r ^ pat_byte_s) & mask_byte_s) != 8'h00);
    if (byte_cnt_r != LW'(N_BYTES)) begin
      byte_inc_s = byte_cnt_r + LW'(1);
    end else begin
      byte_inc_s = byte_cnt_r;
    end
  end

  // Next-state and next-output logic: enable, then frame boundaries, then scl rises.
  always_comb begin
    state_n    = state_r;
    bit_cnt_n  = bit_cnt_r;
    shift_n    = shift_r;
    byte_cnt_n = byte_cnt_r;
    len_n      = len_r;
    pat_n      = pat_r;
    mask_n     = mask_r;
    busy_n     = busy_r;
    rx_byte_n  = rx_byte_r;
    ack_n      = ack_r;
    count_n    = count_r;
    rx_valid_n = 1'b0;
    match_n    = 1'b0;
    mismatch_n = 1'b0;

    if (!enable) begin
      state_n = ST_IDLE;
      busy_n  = 1'b0;
    end else if (state_r == ST_IDLE) begin
      if (start_s) begin
        pat_n      = pattern;
        mask_n     = mask;
        len_n      = LW'(clamp_len(int'(pattern_len), N_BYTES));
        bit_cnt_n  = 3'd0;
        byte_cnt_n = {LW{1'b0}};
        busy_n     = 1'b1;
        state_n    = ST_DATA;
      end else begin
        state_n = ST_IDLE;
      end
    end else if (start_s || stop_s) begin
      case (state_r)
        ST_HIT: begin
          match_n = 1'b1;
          if (count_r != {CNT_W{1'b1}}) begin
            count_n = count_r + CNT_W'(1);
          end else begin
            count_n = count_r;
          end
        end
        ST_DATA, ST_ACK, ST_FAIL: mismatch_n = 1'b1;
        default:                  mismatch_n = 1'b0;
      endcase
      if (start_s) begin
        // Repeated START: open a fresh frame straight away.
        pat_n      = pattern;
        mask_n     = mask;
        len_n      = LW'(clamp_len(int'(pattern_len), N_BYTES));
        bit_cnt_n  = 3'd0;
        byte_cnt_n = {LW{1'b0}};
        busy_n     = 1'b1;
        state_n    = ST_DATA;
      end else begin
        busy_n  = 1'b0;
        state_n = ST_IDLE;
      end
    end else if (rise_s) begin
      case (state_r)
        ST_DATA: begin
          shift_n   = {shift_r[6:0], sda_s};
          bit_cnt_n = bit_cnt_r + 3'd1;
          if (bit_cnt_r == 3'd7) begin
            state_n = ST_ACK;
          end else begin
            state_n = ST_DATA;
          end
        end
        ST_ACK: begin
          ack_n      = sda_s;
          rx_byte_n  = shift_r;
          rx_valid_n = 1'b1;
          byte_cnt_n = byte_inc_s;
          bit_cnt_n  = 3'd0;
          if (byte_bad_s) begin
            state_n = ST_FAIL;
          end else if (byte_inc_s == len_r) begin
            // Completing the pattern wins even if this byte was NACKed.
            state_n = ST_HIT;
          end else if (sda_s) begin
            state_n = ST_FAIL;
          end else begin
            state_n = ST_DATA;
          end
        end
        default: state_n = state_r;
      endcase
    end else begin
      state_n = state_r;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      bit_cnt_r  <= 3'd0;
      shift_r    <= 8'h00;
      byte_cnt_r <= {LW{1'b0}};
      len_r      <= {LW{1'b0}};
      pat_r      <= {(8*N_BYTES){1'b0}};
      mask_r     <= {(8*N_BYTES){1'b0}};
      busy_r     <= 1'b0;
      rx_byte_r  <= 8'h00;
      rx_valid_r <= 1'b0;
      ack_r      <= 1'b0;
      match_r    <= 1'b0;
      mismatch_r <= 1'b0;
      count_r    <= {CNT_W{1'b0}};
    end else begin
      state_r    <= state_n;
      bit_cnt_r  <= bit_cnt_n;
      shift_r    <= shift_n;
      byte_cnt_r <= byte_cnt_n;
      len_r      <= len_n;
      pat_r      <= pat_n;
      mask_r     <= mask_n;
      busy_r     <= busy_n;
      rx_byte_r  <= rx_byte_n;
      rx_valid_r <= rx_valid_n;
      ack_r      <= ack_n;
      match_r    <= match_n;
      mismatch_r <= mismatch_n;
      count_r    <= count_n;
    end
  end

  assign match       = match_r;
  assign mismatch    = mismatch_r;
  assign busy        = busy_r;
  assign rx_byte     = rx_byte_r;
  assign rx_valid    = rx_valid_r;
  assign ack_bit     = ack_r;
  assign byte_cnt    = byte_cnt_r;
  assign match_count = count_r;
  assign state_dbg   = state_r;

endmodule

// File: tb/tb_i2c_pattern_matcher.sv
// Directed bench for i2c_pattern_matcher: bit-banged I2C frames with hand-computed verdicts.
module tb_i2c_pattern_matcher;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        scl;
  logic        sda;
  logic [31:0] pattern;
  logic [31:0] mask;
  logic [2:0]  pattern_len;
  logic        match;
  logic        mismatch;
  logic        busy;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic        ack_bit;
  logic [2:0]  byte_cnt;
  logic [15:0] match_count;
  logic [2:0]  state_dbg;

  int n_chk = 0;
  int n_err = 0;

  int match_total    = 0;
  int mismatch_total = 0;
  int both_total     = 0;
  int rx_total       = 0;
  logic [7:0] rx_hist [0:255];

  int m0;
  int mm0;
  int r0;

  i2c_pattern_matcher #(
    .N_BYTES     (4),
    .SYNC_STAGES (2),
    .CNT_W       (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .scl         (scl),
    .sda         (sda),
    .pattern     (pattern),
    .mask        (mask),
    .pattern_len (pattern_len),
    .match       (match),
    .mismatch    (mismatch),
    .busy        (busy),
    .rx_byte     (rx_byte),
    .rx_valid    (rx_valid),
    .ack_bit     (ack_bit),
    .byte_cnt    (byte_cnt),
    .match_count (match_count),
    .state_dbg   (state_dbg)
  );

  always #5 clk = ~clk;

  // Pulse monitor, sampled on the falling edge away from the active edge.
  always @(negedge clk) begin
    if (rx_valid) begin
      rx_hist[rx_total[7:0]] <= rx_byte;
      rx_total <= rx_total + 1;
    end
    if (match)    match_total    <= match_total + 1;
    if (mismatch) mismatch_total <= mismatch_total + 1;
    if (match && mismatch) both_total <= both_total + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic snap();
    wait_clk(1);
    m0  = match_total;
    mm0 = mismatch_total;
    r0  = rx_total;
  endtask

  task automatic i2c_start();
    scl = 1'b1; sda = 1'b1; wait_clk(10);
    sda = 1'b0;             wait_clk(10);
    scl = 1'b0;             wait_clk(10);
  endtask

  task automatic i2c_rstart();
    sda = 1'b1; wait_clk(5);
    scl = 1'b1; wait_clk(10);
    sda = 1'b0; wait_clk(10);
    scl = 1'b0; wait_clk(5);
  endtask

  task automatic i2c_stop();
    sda = 1'b0; wait_clk(5);
    scl = 1'b1; wait_clk(10);
    sda = 1'b1; wait_clk(10);
  endtask

  task automatic i2c_bit(input logic b);
    sda = b;    wait_clk(5);
    scl = 1'b1; wait_clk(10);
    scl = 1'b0; wait_clk(5);
  endtask

  task automatic i2c_byte(input logic [7:0] b, input logic nack);
    for (int i = 7; i >= 0; i--) i2c_bit(b[i]);
    i2c_bit(nack);
  endtask

  initial begin
    reset       = 1'b1;
    enable      = 1'b1;
    scl         = 1'b1;
    sda         = 1'b1;
    pattern     = 32'h0055_10A0;
    mask        = 32'hFFFF_FFFF;
    pattern_len = 3'd3;
    wait_clk(5);
    reset = 1'b0;
    wait_clk(3);

    // Reset state
    check_eq("reset_flags", {27'd0, match, mismatch, busy, rx_valid, ack_bit}, 32'd0);
    check_eq("reset_rx_byte", {24'd0, rx_byte}, 32'd0);
    check_eq("reset_cnts", {13'd0, byte_cnt, match_count}, 32'd0);
    check_eq("reset_state", {29'd0, state_dbg}, 32'd0);

    // Matching 3-byte frame
    snap();
    i2c_start();
    check_eq("t1_busy", {31'd0, busy}, 32'd1);
    check_eq("t1_state_data", {29'd0, state_dbg}, 32'd1);
    i2c_byte(8'hA0, 1'b0);
    i2c_byte(8'h10, 1'b0);
    i2c_byte(8'h55, 1'b0);
    check_eq("t1_state_hit", {29'd0, state_dbg}, 32'd3);
    i2c_stop();
    wait_clk(10);
    check_eq("t1_rx_count", rx_total - r0, 32'd3);
    check_eq("t1_rx0", {24'd0, rx_hist[r0[7:0]]}, 32'hA0);
    check_eq("t1_rx1", {24'd0, rx_hist[8'(r0 + 1)]}, 32'h10);
    check_eq("t1_rx2", {24'd0, rx_hist[8'(r0 + 2)]}, 32'h55);
    check_eq("t1_match", match_total - m0, 32'd1);
    check_eq("t1_mismatch", mismatch_total - mm0, 32'd0);
    check_eq("t1_match_count", {16'd0, match_count}, 32'd1);
    check_eq("t1_busy_end", {31'd0, busy}, 32'd0);
    check_eq("t1_state_end", {29'd0, state_dbg}, 32'd0);
    check_eq("t1_byte_cnt", {29'd0, byte_cnt}, 32'd3);

    // Wrong second byte
    snap();
    i2c_start();
    i2c_byte(8'hA0, 1'b0);
    i2c_byte(8'h11, 1'b0);
    check_eq("t2_state_fail", {29'd0, state_dbg}, 32'd4);
    i2c_byte(8'h55, 1'b0);
    i2c_stop();
    wait_clk(10);
    check_eq("t2_rx_count", rx_total - r0, 32'd2);
    check_eq("t2_match", match_total - m0, 32'd0);
    check_eq("t2_mismatch", mismatch_total - mm0, 32'd1);
    check_eq("t2_match_count", {16'd0, match_count}, 32'd1);

    // Masked low nibble on byte 1
    mask = 32'hFFFF_F0FF;
    snap();
    i2c_start();
    i2c_byte(8'hA0, 1'b0);
    i2c_byte(8'h1F, 1'b0);
    i2c_byte(8'h55, 1'b0);
    i2c_stop();
    wait_clk(10);
    mask = 32'hFFFF_FFFF;
    check_eq("t3_match", match_total - m0, 32'd1);
    check_eq("t3_mismatch", mismatch_total - mm0, 32'd0);
    check_eq("t3_match_count", {16'd0, match_count}, 32'd2);

    // NACK on first byte
    snap();
    i2c_start();
    i2c_byte(8'hA0, 1'b1);
    check_eq("t4_state_fail", {29'd0, state_dbg}, 32'd4);
    check_eq("t4_ack_bit", {31'd0, ack_bit}, 32'd1);
    i2c_stop();
    wait_clk(10);
    check_eq("t4_mismatch", mismatch_total - mm0, 32'd1);
    check_eq("t4_match", match_total - m0, 32'd0);

    // Short frame
    snap();
    i2c_start();
    i2c_byte(8'hA0, 1'b0);
    i2c_byte(8'h10, 1'b0);
    check_eq("t5_state_data", {29'd0, state_dbg}, 32'd1);
    i2c_stop();
    wait_clk(10);
    check_eq("t5_mismatch", mismatch_total - mm0, 32'd1);
    check_eq("t5_byte_cnt", {29'd0, byte_cnt}, 32'd2);

    // Repeated START
    snap();
    i2c_start();
    i2c_byte(8'hA0, 1'b0);
    check_eq("t6_byte_cnt_1", {29'd0, byte_cnt}, 32'd1);
    i2c_rstart();
    check_eq("t6_rs_mismatch", mismatch_total - mm0, 32'd1);
    check_eq("t6_rs_byte_cnt", {29'd0, byte_cnt}, 32'd0);
    check_eq("t6_rs_busy", {31'd0, busy}, 32'd1);
    check_eq("t6_rs_state", {29'd0, state_dbg}, 32'd1);
    i2c_byte(8'h10, 1'b0);
    i2c_byte(8'h55, 1'b0);
    i2c_stop();
    wait_clk(10);
    check_eq("t6_mismatch", mismatch_total - mm0, 32'd2);
    check_eq("t6_match", match_total - m0, 32'd0);

    // Reset in the middle of a byte
    snap();
    i2c_start();
    for (int i = 7; i >= 4; i--) i2c_bit(1'(8'hA0 >> i));
    reset = 1'b1;
    wait_clk(1);
    check_eq("t7_flags", {27'd0, match, mismatch, busy, rx_valid, ack_bit}, 32'd0);
    check_eq("t7_data", {5'd0, rx_byte, byte_cnt, match_count}, 32'd0);
    check_eq("t7_state", {29'd0, state_dbg}, 32'd0);
    wait_clk(2);
    reset = 1'b0;
    wait_clk(3);
    scl = 1'b1; wait_clk(10);
    sda = 1'b1; wait_clk(10);
    check_eq("t7_no_pulse", (match_total - m0) + (mismatch_total - mm0), 32'd0);
    check_eq("t7_idle", {29'd0, state_dbg}, 32'd0);

    // Disable during a frame
    snap();
    i2c_start();
    i2c_byte(8'hA0, 1'b0);
    enable = 1'b0;
    wait_clk(1);
    check_eq("t8_state", {29'd0, state_dbg}, 32'd0);
    check_eq("t8_busy", {31'd0, busy}, 32'd0);
    i2c_byte(8'h10, 1'b0);
    i2c_stop();
    wait_clk(10);
    enable = 1'b1;
    wait_clk(5);
    check_eq("t8_no_pulse", (match_total - m0) + (mismatch_total - mm0), 32'd0);
    check_eq("t8_byte_cnt_hold", {29'd0, byte_cnt}, 32'd1);
    check_eq("t8_idle", {29'd0, state_dbg}, 32'd0);

    // Zero length behaves as one byte
    pattern_len = 3'd0;
    snap();
    i2c_start();
    i2c_byte(8'hA0, 1'b0);
    check_eq("t9_state_hit", {29'd0, state_dbg}, 32'd3);
    i2c_stop();
    wait_clk(10);
    check_eq("t9_match", match_total - m0, 32'd1);
    check_eq("t9_match_count", {16'd0, match_count}, 32'd1);
    check_eq("t9_byte_cnt", {29'd0, byte_cnt}, 32'd1);

    // Oversize length clamps to 4 bytes; a 3-byte frame is not enough
    pattern_len = 3'd7;
    snap();
    i2c_start();
    i2c_byte(8'hA0, 1'b0);
    i2c_byte(8'h10, 1'b0);
    i2c_byte(8'h55, 1'b0);
    check_eq("t10_state_data", {29'd0, state_dbg}, 32'd1);
    i2c_byte(8'h00, 1'b1);
    i2c_stop();
    wait_clk(10);
    check_eq("t10_match", match_total - m0, 32'd1);
    check_eq("t10_match_count", {16'd0, match_count}, 32'd2);
    check_eq("t10_byte_cnt", {29'd0, byte_cnt}, 32'd4);

    check_eq("never_both", both_total, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/i2c_pattern_matcher.md
Name: i2c_pattern_matcher

Overview:
Passive, clocked I2C bus monitor that compares the bytes of each bus frame against a programmable, per-bit masked byte pattern. It does not drive the bus. It replaces hard-coded SDA/SCL sequence matchers: pattern length, contents and mask are run-time inputs, and matching is byte-based (8 data bits plus ACK) rather than per-edge. It sits beside the I2C pads and feeds the debug/trigger logic a match/mismatch verdict per frame.

Parameters:
N_BYTES, 4, maximum pattern length in bytes
SYNC_STAGES, 2, synchroniser flops on scl and sda (minimum 2)
CNT_W, 16, width of the saturating match counter

Ports:
clk  in  1  system clock; scl/sda are asynchronous to it
reset  in  1  reset, synchronous, active-high
enable  in  1  monitor enable; low forces IDLE
scl  in  1  raw I2C clock line
sda  in  1  raw I2C data line
pattern  in  8*N_BYTES  expected bytes; byte 0 in bits [7:0] is the first byte after START
mask  in  8*N_BYTES  per-bit compare enable; 1 = compare
pattern_len  in  $clog2(N_BYTES+1)  number of bytes to compare
match  out  1  one-cycle pulse: frame matched
mismatch  out  1  one-cycle pulse: frame failed
busy  out  1  high from START until the frame ends
rx_byte  out  8  last received byte
rx_valid  out  1  one-cycle pulse when rx_byte updates
ack_bit  out  1  sda value sampled on the 9th clock of the last byte (0 = ACK)
byte_cnt  out  $clog2(N_BYTES+1)  bytes received in the current frame, saturating at N_BYTES
match_count  out  CNT_W  saturating count of match pulses
state_dbg  out  3  current state encoding

Behaviour:
- Reset (synchronous, active-high):
  - state = IDLE; all outputs 0.
  - Synchroniser flops and prev-samples load 1 (idle bus), so no false START on release.
- Sync/detect:
  - scl_s and sda_s come after SYNC_STAGES flops; scl_p and sda_p hold the previous samples.
  - start = scl_s & scl_p & sda_p & ~sda_s.
  - stop = scl_s & scl_p & ~sda_p & sda_s.
  - rise = scl_s & ~scl_p.
  - start and stop cannot coincide with rise by construction.
- States: IDLE, DATA, ACK, HIT, FAIL.
- Any state except IDLE: start ends the frame (verdict emitted as for stop), then the monitor re-enters DATA with counters cleared. This handles repeated START.
- IDLE, on start:
  - Latch pattern, mask and the effective length L. L = pattern_len, except 0 gives 1 and values above N_BYTES give N_BYTES.
  - Clear bit and byte counters, set busy, go to DATA.
- DATA: on each rise, shift sda_s into the byte MSB-first. After the 8th bit go to ACK.
- ACK, on rise:
  - ack_bit = sda_s; rx_byte = the shifted byte; rx_valid pulses; byte_cnt increments.
  - If the byte index is below L and ((byte ^ pattern[idx]) & mask[idx]) != 0, go to FAIL.
  - Else if byte_cnt reaches L, go to HIT.
  - Else if ack_bit = 1 (NACK), go to FAIL.
  - Else go to DATA.
  - A NACK on the byte that completes L still goes to HIT.
- HIT and FAIL ignore scl edges until stop or start.
- Frame end (stop, or start while busy):
  - From HIT: match pulses and match_count increments, saturating at all-ones.
  - From DATA, ACK or FAIL: mismatch pulses.
  - Then busy = 0 and the state becomes IDLE (or DATA if the end was a start).
- stop while in IDLE: ignored, no pulse.
- Latency: a match/mismatch pulse is registered SYNC_STAGES+1 clk cycles after the raw sda edge and lasts exactly 1 cycle. match and mismatch are never high together.
- enable = 0: next cycle state = IDLE, busy = 0, no pulses. An aborted frame emits no verdict. Counters and match_count hold. Edge detection keeps running, so re-enable needs a fresh START.
- Pattern inputs changing mid-frame have no effect until the next START.

Decomposition:
- Package i2c_mon_pkg holds:
  - the state enum (IDLE=0, DATA=1, ACK=2, HIT=3, FAIL=4);
  - a BITS_PER_BYTE=8 constant;
  - a function clamping pattern_len.
- Sub-module i2c_bus_sync (scl/sda synchroniser with start/stop/rise detection) is natural and reusable by later I2C blocks.

Test Plan:
- Bench setup: N_BYTES=4; pattern 0xA0, 0x10, 0x55; mask all FF; len 3; SCL period 20 clk; frame START A0/ACK 10/ACK 55/ACK STOP → rx_valid ×3 (A0, 10, 55), match pulses once, match_count=1, busy low afterwards.
- Same config, second byte 0x11 → FAIL after byte 1, mismatch pulses at STOP, no match, match_count unchanged.
- Mask byte1 = 0xF0, second byte 0x1F → match.
- pattern_len=3, NACK after byte 0xA0 → FAIL, mismatch at STOP.
- pattern_len=3, STOP after 2 bytes → mismatch.
- START A0/ACK, repeated START, then 10/55 → mismatch for the first frame, then a new frame with byte_cnt cleared.
- reset asserted mid-byte → all outputs 0 next cycle, no pulse.
- enable=0 during a frame → IDLE, no verdict.
- pattern_len=0 with byte A0 → behaves as length 1, match.
